// File: rtl/instr_prefetch_pkg.sv
// Shared instruction-format constants for the fetch and decode stages.
// The NOP encoding is substituted whenever the front end has no real instruction.
package instr_prefetch_pkg;

  localparam int INSTR_W   = 16;
  localparam int OPCODE_W  = 6;
  localparam int SRC_W     = 3;
  localparam int DST_W     = 3;
  localparam int SHAMT_W   = 4;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [SRC_W-1:0]    src;
    logic [DST_W-1:0]    dst;
    logic [SHAMT_W-1:0]  shamt;
  } instr_fields_t;

  localparam instr_fields_t NOP_FIELDS = '{
    opcode: 6'b000101,
    src:    3'b000,
    dst:    3'b011,
    shamt:  4'b0000
  };

  localparam logic [INSTR_W-1:0] NOP_INSTR = NOP_FIELDS;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
// Pointers carry one extra MSB so that full and empty are distinguishable.
module instr_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign q     = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[PTR_W-1:0]] <= data;
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch front end: owns the PC, issues reads to a 1-cycle instruction memory,
// and queues responses for the F/D buffer with redirect and stall handling.
module instr_prefetch_unit
  import instr_prefetch_pkg::*;
#(
  parameter int                W        = INSTR_W,
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_rvalid,
  input  logic [W-1:0]             imem_rdata,
  input  logic                     redirect_en,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     dec_ready,
  output logic                     instr_valid,
  output logic [W-1:0]             instr_out,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + W;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               inflight;
  logic               enq;
  logic               deq;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W:0]     credits_used;

  // Slots already promised (queued plus in flight) must leave room for the new request.
  assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign imem_req     = !rst && !redirect_en && !fifo_full &&
                        (credits_used < (CNT_W+1)'(DEPTH));
  assign imem_addr    = pc;

  // Gating on inflight drops any response we did not ask for (e.g. after reset).
  assign enq = imem_rvalid && inflight && !redirect_en && !rst;
  assign deq = instr_valid && dec_ready && !redirect_en && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (redirect_en) begin
        pc <= redirect_pc;
      end else if (imem_req) begin
        pc     <= pc + ADDR_W'(1);
        req_pc <= pc;
      end
    end
  end

  instr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (enq),
    .rd_en (deq),
    .flush (redirect_en),
    .data  ({req_pc, imem_rdata}),
    .q     (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign instr_valid = !fifo_empty;
  assign instr_out   = instr_valid ? head[W-1:0] : W'(NOP_INSTR);
  assign instr_pc    = instr_valid ? head[ENTRY_W-1:W] : '0;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit: a cycle table for free-run and stall,
// plus hand sequences for redirect, PC wrap and reset corner cases.
module tb_instr_prefetch_unit;

  localparam logic [15:0] NOP = 16'h1430;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_en;
  logic [9:0]  redirect_pc;
  logic        dec_ready;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [9:0]  instr_pc;
  logic [2:0]  fifo_count;

  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        stale_valid;

  int checks_done = 0;
  int check_fails = 0;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [9:0]  rpc;
    logic        rdy;
    logic        req;
    logic [9:0]  addr;
    logic        valid;
    logic [9:0]  ipc;
    logic [15:0] instr;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  instr_prefetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .dec_ready   (dec_ready),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: one-cycle latency, data = address + 0x100.
  always @(posedge clk) begin
    mem_rvalid <= imem_req;
    mem_rdata  <= 16'h0100 + {6'b0, imem_addr};
  end

  assign imem_rvalid = mem_rvalid | stale_valid;
  assign imem_rdata  = stale_valid ? 16'hDEAD : mem_rdata;

  task automatic apply_stimulus(input logic r, input logic red, input logic [9:0] rpc,
                                input logic rdy, input logic stale);
    @(posedge clk);
    #1;
    rst         = r;
    redirect_en = red;
    redirect_pc = rpc;
    dec_ready   = rdy;
    stale_valid = stale;
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks_done++;
    if (got !== exp) begin
      check_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic red, input logic [9:0] rpc, input logic rdy,
                         input logic req, input logic [9:0] addr, input logic valid,
                         input logic [9:0] ipc, input logic [15:0] instr, input logic [2:0] cnt);
    vec_t v;
    v.rst = r; v.redir = red; v.rpc = rpc; v.rdy = rdy;
    v.req = req; v.addr = addr; v.valid = valid; v.ipc = ipc; v.instr = instr; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; dec_ready = 1'b0; stale_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Free run with dec_ready high, then reset and stall from cycle 3.
    //       rst red rpc   rdy  req addr   vld ipc    instr     cnt
    add_vec(1, 0, 10'h0, 1,   0, 10'h0,  0, 10'h0, NOP,      3'd0);
    add_vec(0, 0, 10'h0, 1,   1, 10'h0,  0, 10'h0, NOP,      3'd0);
    add_vec(0, 0, 10'h0, 1,   1, 10'h1,  0, 10'h0, NOP,      3'd0);
    add_vec(0, 0, 10'h0, 1,   1, 10'h2,  1, 10'h0, 16'h0100, 3'd1);
    add_vec(0, 0, 10'h0, 1,   1, 10'h3,  1, 10'h1, 16'h0101, 3'd1);
    add_vec(0, 0, 10'h0, 1,   1, 10'h4,  1, 10'h2, 16'h0102, 3'd1);
    add_vec(0, 0, 10'h0, 1,   1, 10'h5,  1, 10'h3, 16'h0103, 3'd1);
    add_vec(1, 0, 10'h0, 0,   0, 10'h6,  1, 10'h4, 16'h0104, 3'd1);
    add_vec(0, 0, 10'h0, 0,   1, 10'h0,  0, 10'h0, NOP,      3'd0);
    add_vec(0, 0, 10'h0, 0,   1, 10'h1,  0, 10'h0, NOP,      3'd0);
    add_vec(0, 0, 10'h0, 0,   1, 10'h2,  1, 10'h0, 16'h0100, 3'd1);
    add_vec(0, 0, 10'h0, 0,   1, 10'h3,  1, 10'h0, 16'h0100, 3'd2);
    add_vec(0, 0, 10'h0, 0,   0, 10'h4,  1, 10'h0, 16'h0100, 3'd3);
    add_vec(0, 0, 10'h0, 0,   0, 10'h4,  1, 10'h0, 16'h0100, 3'd4);
    add_vec(0, 0, 10'h0, 0,   0, 10'h4,  1, 10'h0, 16'h0100, 3'd4);
    add_vec(0, 0, 10'h0, 1,   0, 10'h4,  1, 10'h0, 16'h0100, 3'd4);
    add_vec(0, 0, 10'h0, 1,   1, 10'h4,  1, 10'h1, 16'h0101, 3'd3);
    add_vec(0, 0, 10'h0, 1,   1, 10'h5,  1, 10'h2, 16'h0102, 3'd2);
    add_vec(0, 0, 10'h0, 1,   1, 10'h6,  1, 10'h3, 16'h0103, 3'd2);
    add_vec(0, 0, 10'h0, 1,   1, 10'h7,  1, 10'h4, 16'h0104, 3'd2);
    add_vec(0, 0, 10'h0, 1,   1, 10'h8,  1, 10'h5, 16'h0105, 3'd2);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy, 1'b0);
      check_output($sformatf("vec%0d.req", i),   imem_req,    vecs[i].req);
      check_output($sformatf("vec%0d.addr", i),  imem_addr,   vecs[i].addr);
      check_output($sformatf("vec%0d.valid", i), instr_valid, vecs[i].valid);
      check_output($sformatf("vec%0d.pc", i),    instr_pc,    vecs[i].ipc);
      check_output($sformatf("vec%0d.instr", i), instr_out,   vecs[i].instr);
      check_output($sformatf("vec%0d.count", i), fifo_count,  vecs[i].cnt);
    end

    // Redirect with three entries queued and one response in flight.
    apply_stimulus(1, 0, 10'h0, 0, 0);
    repeat (4) apply_stimulus(0, 0, 10'h0, 0, 0);
    apply_stimulus(0, 1, 10'h02A, 0, 0);
    check_output("redir.t.count", fifo_count, 3'd3);
    check_output("redir.t.req", imem_req, 1'b0);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("redir.t1.count", fifo_count, 3'd0);
    check_output("redir.t1.valid", instr_valid, 1'b0);
    check_output("redir.t1.instr", instr_out, NOP);
    check_output("redir.t1.req", imem_req, 1'b1);
    check_output("redir.t1.addr", imem_addr, 10'h02A);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("redir.t2.valid", instr_valid, 1'b0);
    check_output("redir.t2.addr", imem_addr, 10'h02B);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("redir.t3.valid", instr_valid, 1'b1);
    check_output("redir.t3.pc", instr_pc, 10'h02A);
    check_output("redir.t3.instr", instr_out, 16'h012A);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("redir.t4.pc", instr_pc, 10'h02B);
    check_output("redir.t4.instr", instr_out, 16'h012B);

    // PC wrap from the top of the address space.
    apply_stimulus(0, 1, 10'h3FE, 1, 0);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("wrap.addr0", imem_addr, 10'h3FE);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("wrap.addr1", imem_addr, 10'h3FF);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("wrap.addr2", imem_addr, 10'h000);
    check_output("wrap.head0.pc", instr_pc, 10'h3FE);
    check_output("wrap.head0.instr", instr_out, 16'h04FE);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("wrap.addr3", imem_addr, 10'h001);
    check_output("wrap.head1.pc", instr_pc, 10'h3FF);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("wrap.head2.pc", instr_pc, 10'h000);
    check_output("wrap.head2.instr", instr_out, 16'h0100);

    // Reset and redirect together: reset wins.
    apply_stimulus(1, 1, 10'h155, 1, 0);
    check_output("rstredir.req", imem_req, 1'b0);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("rstredir.addr", imem_addr, 10'h000);
    check_output("rstredir.count", fifo_count, 3'd0);
    check_output("rstredir.valid", instr_valid, 1'b0);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    apply_stimulus(0, 0, 10'h0, 1, 0);
    check_output("rstredir.head.pc", instr_pc, 10'h000);
    check_output("rstredir.head.instr", instr_out, 16'h0100);

    // Reset while full and stalled, with a stale response the cycle after.
    apply_stimulus(1, 0, 10'h0, 0, 0);
    repeat (7) apply_stimulus(0, 0, 10'h0, 0, 0);
    check_output("full.count", fifo_count, 3'd4);
    check_output("full.req", imem_req, 1'b0);
    apply_stimulus(1, 0, 10'h0, 0, 0);
    apply_stimulus(0, 0, 10'h0, 0, 1);
    check_output("fullrst.valid", instr_valid, 1'b0);
    check_output("fullrst.instr", instr_out, NOP);
    check_output("fullrst.pc", instr_pc, 10'h000);
    check_output("fullrst.count", fifo_count, 3'd0);
    check_output("fullrst.addr", imem_addr, 10'h000);
    apply_stimulus(0, 0, 10'h0, 0, 0);
    check_output("stale.count", fifo_count, 3'd0);
    check_output("stale.valid", instr_valid, 1'b0);
    apply_stimulus(0, 0, 10'h0, 0, 0);
    check_output("refetch.pc", instr_pc, 10'h000);
    check_output("refetch.instr", instr_out, 16'h0100);
    check_output("refetch.count", fifo_count, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, check_fails);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
- Front-end stage directly upstream of the F/D pipeline buffer.
- Owns the program counter and issues word reads to a 1-cycle-latency instruction memory.
- Queues returned instructions in a small prefetch FIFO and presents them to the F/D buffer with a valid/ready handshake.
- Handles decode stalls and PC redirects (branch/flush), substituting the NOP encoding whenever no instruction is valid.

Parameters:
- W, 16, instruction/data width.
- ADDR_W, 10, instruction memory word-address width.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  word address of request (current PC).
- imem_rvalid  in  1  response valid; asserted exactly one cycle after imem_req.
- imem_rdata  in  W  instruction word, valid with imem_rvalid.
- redirect_en  in  1  discard queued/in-flight fetches and load new PC.
- redirect_pc  in  ADDR_W  target PC for redirect.
- dec_ready  in  1  F/D buffer accepts an instruction this cycle.
- instr_valid  out  1  instr_out/instr_pc hold a real instruction.
- instr_out  out  W  FIFO head instruction, or NOP (16'b000101_000_011_0000) when not valid.
- instr_pc  out  ADDR_W  PC of instr_out; 0 when not valid.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge): pc<=RESET_PC, FIFO emptied, inflight<=0.
  - Outputs after reset: instr_valid=0, instr_out=NOP, instr_pc=0, fifo_count=0.
  - imem_req is forced 0 while rst=1.
  - Reset mid-operation drops everything; any imem_rvalid in the cycle after reset is ignored.
- inflight register = imem_req of the previous cycle (fixed 1-cycle memory latency).
- Issue rule: imem_req = !rst && !redirect_en && (fifo_count + inflight < DEPTH); imem_addr = pc.
- On issue, pc <= pc+1, wrapping modulo 2^ADDR_W (address 2^ADDR_W-1 is followed by 0).
- Enqueue: when imem_rvalid && !redirect_en && !rst, the pair {pc_of_request, imem_rdata} is written at the FIFO tail.
  - pc_of_request is captured in a register at issue time.
- Dequeue: when instr_valid && dec_ready && !redirect_en, the head pops.
- instr_valid = (fifo_count != 0); head is read combinationally from registered storage.
- Simultaneous enqueue and dequeue: fifo_count unchanged, both pointers advance.
- Full: no request is issued; credit counting includes inflight, so an overflow write is impossible.
- Empty: instr_valid=0 and instr_out=NOP regardless of dec_ready.
- Redirect (redirect_en=1 in cycle t):
  - FIFO is flushed (count<=0, pointers reset) and pc<=redirect_pc.
  - No request is issued in cycle t.
  - A response arriving in cycle t is dropped.
  - Request for redirect_pc issues in t+1, its response arrives in t+2, and instr_valid=1 from t+3.
- Redirect has priority over stall and over enqueue/dequeue.
- rst has priority over redirect.
- Steady-state latency: request at t, response at t+1, visible at head at t+2.
- With dec_ready held high: one instruction per cycle sustained once primed.
- Stall (dec_ready=0): head and instr_valid hold stable; fetching continues until the FIFO plus the in-flight request reaches DEPTH.

Decomposition:
- Shared package holds: W, the opcode/src/dst/shamt field widths, and the NOP encoding constant, all shared with the decode stage.
- One sub-module: instr_fifo, a synchronous FIFO of {ADDR_W+W} bits with DEPTH entries.
  - Ports: wr_en, rd_en, flush, data, count, empty, full.
  - Pointer wrap uses an extra MSB for the full/empty distinction.
- Top level contains the PC, inflight register, credit logic, and output NOP muxing.

Test Plan:
- Reset then free-run, dec_ready=1, memory returns data=addr+16'h100 → imem_addr 0,1,2,... from cycle 1; instr_valid rises at cycle 3 with instr_pc=0, instr_out=16'h0100; one new PC per cycle thereafter.
- dec_ready=0 from cycle 3, DEPTH=4 → exactly 4 requests are accepted into the FIFO, imem_req stays 0 once full, head holds pc=0; release dec_ready → pcs 0,1,2,3,4... drain in order with no gap or duplicate.
- redirect_en at cycle t with redirect_pc=0x2A while the FIFO holds 3 entries and a response is in flight → fifo_count=0 at t+1; dropped response is never seen; imem_addr=0x2A at t+1; instr_valid with pc=0x2A at t+3.
- redirect_en and rst asserted in the same cycle → after reset, pc=RESET_PC and the redirect target is ignored.
- pc starts at 2^ADDR_W-2 (redirect to 0x3FE) → imem_addr sequence is 0x3FE, 0x3FF, 0x000, 0x001.
- rst pulsed while the FIFO is full and dec_ready=0 → next cycle instr_valid=0, instr_out=NOP, fifo_count=0; a stale imem_rvalid is ignored; refetch starts at RESET_PC.
